// File: rtl/spi_xfer_seq_if.sv
// Command, FIFO-status, shifter-handshake and status signals of the SPI
// transaction sequencer. The slave modport is the sequencer; the master
// modport is the register/bus side together with the shifter/clock model.
interface spi_xfer_seq_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_keep_cs;
  logic             abort;
  logic             tx_avail;
  logic             rx_space;
  logic             tx_done;
  logic             rx_done;
  logic             rtx_done;
  logic             byte_start;
  logic [1:0]       byte_mode;
  logic             tx_pop;
  logic             rx_push;
  logic             cs_n;
  logic             busy;
  logic [CNT_W-1:0] bytes_left;
  logic             xfer_done;
  logic             xfer_err;

  modport master (
    output cmd_valid, cmd_mode, cmd_len, cmd_keep_cs, abort,
           tx_avail, rx_space, tx_done, rx_done, rtx_done,
    input  cmd_ready, byte_start, byte_mode, tx_pop, rx_push,
           cs_n, busy, bytes_left, xfer_done, xfer_err
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, cmd_keep_cs, abort,
           tx_avail, rx_space, tx_done, rx_done, rtx_done,
    output cmd_ready, byte_start, byte_mode, tx_pop, rx_push,
           cs_n, busy, bytes_left, xfer_done, xfer_err
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: byte-level transaction sequencer for the SPI path.
// Owns chip-select setup/hold timing, per-byte issue gating on FIFO status,
// byte counting, the WAIT_DONE watchdog and abort handling.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no command; cs_n may still be low when held by keep_cs
// SETUP     | cs_n low, waiting out the setup time before the first byte
// WAIT_DATA | waiting for TX data / RX space before issuing a byte
// WAIT_DONE | byte in flight, waiting for the mode-matched done pulse
// HOLD      | cs_n hold time before release; exit pulse is done or err
module spi_xfer_seq #(
  parameter int CNT_W    = 16,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TMO_CYC  = 65535
) (
  input logic           clk,
  input logic           rst,
  spi_xfer_seq_if.slave sif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  localparam logic [1:0] MODE_TX  = 2'b01;
  localparam logic [1:0] MODE_RX  = 2'b10;
  localparam logic [1:0] MODE_RTX = 2'b11;

  localparam int TM_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TM_W   = (TM_MAX < 2) ? 1 : $clog2(TM_MAX);
  localparam int WD_W   = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);

  // byte_start is registered, so WAIT_DATA already costs one of the setup
  // cycles; SETUP itself only covers the remaining CS_SETUP-1 cycles.
  localparam logic [TM_W-1:0]  SETUP_LD = TM_W'((CS_SETUP > 1) ? CS_SETUP - 2 : 0);
  localparam logic [TM_W-1:0]  HOLD_LD  = TM_W'(CS_HOLD - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] LEFT_ONE = CNT_W'(1);

  logic [2:0]       state_q, state_nx;
  logic             cs_n_q, cs_n_nx;
  logic [1:0]       mode_q, mode_nx;
  logic [CNT_W-1:0] left_q, left_nx;
  logic             keep_q, keep_nx;
  logic             err_q, err_nx;
  logic [TM_W-1:0]  tmr_q, tmr_nx;
  logic [WD_W-1:0]  wd_q, wd_nx;
  logic             start_q, start_nx;
  logic             pop_q, pop_nx;
  logic             push_q, push_nx;
  logic             xdone_q, xdone_nx;
  logic             xerr_q, xerr_nx;
  logic             busy_q;
  logic             ready_q;

  logic             data_ok;
  logic             done_hit;

  // Byte may go once the FIFOs the current mode touches are ready.
  assign data_ok = (mode_q == MODE_TX) ? sif.tx_avail :
                   (mode_q == MODE_RX) ? sif.rx_space :
                   (sif.tx_avail && sif.rx_space);

  // Only the done pulse of the latched mode finishes a byte.
  assign done_hit = ((mode_q == MODE_TX)  && sif.tx_done) ||
                    ((mode_q == MODE_RX)  && sif.rx_done) ||
                    ((mode_q == MODE_RTX) && sif.rtx_done);

  assign sif.cmd_ready  = ready_q;
  assign sif.byte_start = start_q;
  assign sif.byte_mode  = mode_q;
  assign sif.tx_pop     = pop_q;
  assign sif.rx_push    = push_q;
  assign sif.cs_n       = cs_n_q;
  assign sif.busy       = busy_q;
  assign sif.bytes_left = left_q;
  assign sif.xfer_done  = xdone_q;
  assign sif.xfer_err   = xerr_q;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_nx = state_q;
    cs_n_nx  = cs_n_q;
    mode_nx  = mode_q;
    left_nx  = left_q;
    keep_nx  = keep_q;
    err_nx   = err_q;
    tmr_nx   = tmr_q;
    wd_nx    = wd_q;
    start_nx = 1'b0;
    pop_nx   = 1'b0;
    push_nx  = 1'b0;
    xdone_nx = 1'b0;
    xerr_nx  = 1'b0;

    case (state_q)
      S_IDLE: begin
        err_nx = 1'b0;
        // Abort wins over a command offered in the same cycle.
        if (sif.abort) begin
          cs_n_nx = 1'b1;
        end else if (sif.cmd_valid && ready_q) begin
          if (sif.cmd_mode == 2'b00) begin
            xerr_nx = 1'b1;
          end else if (sif.cmd_len == '0) begin
            xdone_nx = 1'b1;
          end else begin
            mode_nx = sif.cmd_mode;
            left_nx = sif.cmd_len;
            keep_nx = sif.cmd_keep_cs;
            if (cs_n_q) begin
              cs_n_nx = 1'b0;
              if (CS_SETUP > 1) begin
                state_nx = S_SETUP;
                tmr_nx   = SETUP_LD;
              end else begin
                state_nx = S_WAIT_DATA;
              end
            end else begin
              state_nx = S_WAIT_DATA;
            end
          end
        end
      end

      S_SETUP: begin
        if (sif.abort) begin
          err_nx   = 1'b1;
          state_nx = S_HOLD;
          tmr_nx   = HOLD_LD;
        end else if (tmr_q == '0) begin
          state_nx = S_WAIT_DATA;
        end else begin
          tmr_nx = tmr_q - 1'b1;
        end
      end

      S_WAIT_DATA: begin
        if (sif.abort) begin
          err_nx   = 1'b1;
          state_nx = S_HOLD;
          tmr_nx   = HOLD_LD;
        end else if (data_ok) begin
          start_nx = 1'b1;
          pop_nx   = mode_q[0];
          state_nx = S_WAIT_DONE;
          wd_nx    = '0;
        end
      end

      S_WAIT_DONE: begin
        if (done_hit) begin
          if (left_q != '0) begin
            left_nx = left_q - 1'b1;
          end
          push_nx = mode_q[1];
          if (sif.abort) begin
            err_nx   = 1'b1;
            state_nx = S_HOLD;
            tmr_nx   = HOLD_LD;
          end else if (left_q <= LEFT_ONE) begin
            if (keep_q) begin
              xdone_nx = 1'b1;
              state_nx = S_IDLE;
            end else begin
              state_nx = S_HOLD;
              tmr_nx   = HOLD_LD;
            end
          end else begin
            state_nx = S_WAIT_DATA;
          end
        end else if (sif.abort || (wd_q == WD_LAST)) begin
          // Abort or watchdog expiry: the in-flight byte is dropped.
          err_nx   = 1'b1;
          state_nx = S_HOLD;
          tmr_nx   = HOLD_LD;
        end else begin
          wd_nx = wd_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (sif.abort) begin
          err_nx = 1'b1;
        end
        if (tmr_q == '0) begin
          cs_n_nx  = 1'b1;
          state_nx = S_IDLE;
          xerr_nx  = err_nx;
          xdone_nx = !err_nx;
        end else begin
          tmr_nx = tmr_q - 1'b1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        cs_n_nx  = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; async reset drops cs_n at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cs_n_q  <= 1'b1;
      mode_q  <= '0;
      left_q  <= '0;
      keep_q  <= 1'b0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      wd_q    <= '0;
      start_q <= 1'b0;
      pop_q   <= 1'b0;
      push_q  <= 1'b0;
      xdone_q <= 1'b0;
      xerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      cs_n_q  <= cs_n_nx;
      mode_q  <= mode_nx;
      left_q  <= left_nx;
      keep_q  <= keep_nx;
      err_q   <= err_nx;
      tmr_q   <= tmr_nx;
      wd_q    <= wd_nx;
      start_q <= start_nx;
      pop_q   <= pop_nx;
      push_q  <= push_nx;
      xdone_q <= xdone_nx;
      xerr_q  <= xerr_nx;
      busy_q  <= (state_nx != S_IDLE);
      ready_q <= (state_nx == S_IDLE);
    end
  end

endmodule
